// File: rtl/iob_clint_top.sv
// Core-local interruptor: mtime, per-hart mtimecmp and msip on a native bus.
// rtc is synchronized into clk; every rising edge advances mtime by one.
module iob_clint_top #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int N_CORES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rtc,
    input  logic                valid,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   rdata,
    output logic                ready,
    output logic [N_CORES-1:0]  mtip,
    output logic [N_CORES-1:0]  msip
);

    localparam logic [ADDR_W-1:0] MTIME_LO = ADDR_W'(32'hBFF8);
    localparam logic [ADDR_W-1:0] MTIME_HI = ADDR_W'(32'hBFFC);

    logic                rtc_s1, rtc_s2, rtc_d;
    logic                tick;
    logic [63:0]         mtime;
    logic [63:0]         mtimecmp [N_CORES];
    logic [N_CORES-1:0]  msip_q;
    logic [N_CORES-1:0]  mtip_q;

    logic                we;
    logic                mt_lo_we, mt_hi_we;
    logic [N_CORES-1:0]  msip_we, cmp_lo_we, cmp_hi_we;
    logic [DATA_W-1:0]   rd_val;

    function automatic logic [DATA_W-1:0] merge(
        input logic [DATA_W-1:0]   old,
        input logic [DATA_W-1:0]   d,
        input logic [DATA_W/8-1:0] s
    );
        logic [DATA_W-1:0] r;
        r = old;
        for (int b = 0; b < DATA_W/8; b++)
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    assign tick = rtc_s2 & ~rtc_d;
    assign we   = valid & (|wstrb);

    always_comb begin
        rd_val    = '0;
        mt_lo_we  = 1'b0;
        mt_hi_we  = 1'b0;
        msip_we   = '0;
        cmp_lo_we = '0;
        cmp_hi_we = '0;
        if (address == MTIME_LO) begin
            rd_val   = mtime[31:0];
            mt_lo_we = we;
        end
        if (address == MTIME_HI) begin
            rd_val   = mtime[63:32];
            mt_hi_we = we;
        end
        for (int h = 0; h < N_CORES; h++) begin
            if (address == ADDR_W'(4 * h)) begin
                rd_val     = DATA_W'(msip_q[h]);
                msip_we[h] = we;
            end
            if (address == ADDR_W'(32'h4000 + 8 * h)) begin
                rd_val       = mtimecmp[h][31:0];
                cmp_lo_we[h] = we;
            end
            if (address == ADDR_W'(32'h4004 + 8 * h)) begin
                rd_val       = mtimecmp[h][63:32];
                cmp_hi_we[h] = we;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rtc_s1 <= 1'b0;
            rtc_s2 <= 1'b0;
            rtc_d  <= 1'b0;
            ready  <= 1'b0;
            rdata  <= '0;
        end else begin
            rtc_s1 <= rtc;
            rtc_s2 <= rtc_s1;
            rtc_d  <= rtc_s2;
            ready  <= valid;
            if (valid) rdata <= rd_val;
        end
    end

    // A bus write to either mtime word swallows a coincident tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime <= '0;
        end else if (mt_lo_we) begin
            mtime[31:0] <= merge(mtime[31:0], wdata, wstrb);
        end else if (mt_hi_we) begin
            mtime[63:32] <= merge(mtime[63:32], wdata, wstrb);
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            msip_q <= '0;
            mtip_q <= '0;
            for (int h = 0; h < N_CORES; h++)
                mtimecmp[h] <= '1;
        end else begin
            for (int h = 0; h < N_CORES; h++) begin
                if (msip_we[h] && wstrb[0])
                    msip_q[h] <= wdata[0];
                if (cmp_lo_we[h])
                    mtimecmp[h][31:0] <= merge(mtimecmp[h][31:0], wdata, wstrb);
                if (cmp_hi_we[h])
                    mtimecmp[h][63:32] <= merge(mtimecmp[h][63:32], wdata, wstrb);
                mtip_q[h] <= (mtime >= mtimecmp[h]);
            end
        end
    end

    assign mtip = mtip_q;
    assign msip = msip_q;

endmodule

// File: tb/tb_iob_clint_top.sv
// Directed bench for iob_clint_top: bus access, msip, mtime/mtimecmp, reset.
// rtc pulses are driven by hand, four clk cycles high and four low.
module tb_iob_clint_top;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rtc = 1'b0;
    logic        valid = 1'b0;
    logic [15:0] address = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic [31:0] rdata;
    logic        ready;
    logic [0:0]  mtip;
    logic [0:0]  msip;

    int checks = 0;
    int fails  = 0;

    iob_clint_top #(.ADDR_W(16), .DATA_W(32), .N_CORES(1)) dut (
        .clk(clk), .rst(rst), .rtc(rtc),
        .valid(valid), .address(address), .wdata(wdata), .wstrb(wstrb),
        .rdata(rdata), .ready(ready), .mtip(mtip), .msip(msip)
    );

    always #5 clk = ~clk;

    task automatic bus_write(input logic [15:0] a, input logic [31:0] d,
                             input logic [3:0] s);
        @(negedge clk);
        valid = 1'b1; address = a; wdata = d; wstrb = s;
        @(negedge clk);
        valid = 1'b0; wstrb = '0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [31:0] d,
                            output logic r);
        @(negedge clk);
        valid = 1'b1; address = a; wstrb = '0;
        @(negedge clk);
        valid = 1'b0;
        d = rdata;
        r = ready;
    endtask

    task automatic rtc_pulse(input int n);
        for (int i = 0; i < n; i++) begin
            rtc = 1'b1;
            repeat (4) @(negedge clk);
            rtc = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic        r;
        repeat (3) @(negedge clk);
        checks++;
        if (mtip !== 1'b0 || msip !== 1'b0 || ready !== 1'b0 || rdata !== 32'h0) begin
            fails++;
            $display("FAIL reset_outputs: mtip=%b msip=%b ready=%b rdata=%h want 0", mtip, msip, ready, rdata);
        end
        rst = 1'b1;
        bus_read(16'hBFF8, d, r);
        checks++;
        if (d !== 32'h0 || r !== 1'b1) begin
            fails++;
            $display("FAIL reset_mtime_lo: rdata=%h ready=%b want 0/1", d, r);
        end
        @(negedge clk);
        checks++;
        if (ready !== 1'b0) begin
            fails++;
            $display("FAIL ready_single: ready=%b want 0", ready);
        end
        bus_read(16'h4004, d, r);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin
            fails++;
            $display("FAIL reset_cmp_hi: got %h want ffffffff", d);
        end
    endtask

    task automatic test_strobe;
        logic [31:0] d;
        logic        r;
        bus_write(16'h4000, 32'h0000_00AB, 4'h1);
        bus_read(16'h4000, d, r);
        checks++;
        if (d !== 32'hFFFF_FFAB) begin
            fails++;
            $display("FAIL byte_strobe: got %h want ffffffab", d);
        end
        bus_write(16'h4000, 32'h1234_5678, 4'hC);
        bus_read(16'h4000, d, r);
        checks++;
        if (d !== 32'h1234_FFAB) begin
            fails++;
            $display("FAIL upper_strobe: got %h want 1234ffab", d);
        end
        bus_write(16'h4000, 32'hFFFF_FFFF, 4'hF);
    endtask

    task automatic test_msip;
        logic [31:0] d;
        logic        r;
        bus_write(16'h0000, 32'h1, 4'hF);
        checks++;
        if (msip !== 1'b1) begin
            fails++;
            $display("FAIL msip_set: msip=%b want 1", msip);
        end
        bus_write(16'h0000, 32'h0, 4'hF);
        checks++;
        if (msip !== 1'b0) begin
            fails++;
            $display("FAIL msip_clr: msip=%b want 0", msip);
        end
        bus_write(16'h0000, 32'hFFFF_FFFF, 4'hF);
        bus_read(16'h0000, d, r);
        checks++;
        if (d !== 32'h1) begin
            fails++;
            $display("FAIL msip_mask: got %h want 00000001", d);
        end
        bus_write(16'h0000, 32'h0, 4'hF);
    endtask

    task automatic test_unmapped;
        logic [31:0] d;
        logic        r;
        bus_write(16'h0004, 32'h1, 4'hF);
        checks++;
        if (msip !== 1'b0) begin
            fails++;
            $display("FAIL hart1_write: msip=%b want 0", msip);
        end
        bus_read(16'h0004, d, r);
        checks++;
        if (d !== 32'h0 || r !== 1'b1) begin
            fails++;
            $display("FAIL hart1_read: rdata=%h ready=%b want 0/1", d, r);
        end
        bus_write(16'h4008, 32'h5, 4'hF);
        bus_read(16'h4008, d, r);
        checks++;
        if (d !== 32'h0 || r !== 1'b1) begin
            fails++;
            $display("FAIL cmp1_read: rdata=%h ready=%b want 0/1", d, r);
        end
        bus_read(16'h1234, d, r);
        checks++;
        if (d !== 32'h0 || r !== 1'b1) begin
            fails++;
            $display("FAIL hole_read: rdata=%h ready=%b want 0/1", d, r);
        end
    endtask

    task automatic test_timer;
        logic [31:0] d;
        logic        r;
        bus_write(16'h4000, 32'd200, 4'hF);
        bus_write(16'h4004, 32'd0, 4'hF);
        rtc_pulse(199);
        checks++;
        if (mtip !== 1'b0) begin
            fails++;
            $display("FAIL mtip_early: mtip=%b want 0", mtip);
        end
        bus_read(16'hBFF8, d, r);
        checks++;
        if (d !== 32'd199) begin
            fails++;
            $display("FAIL mtime_199: got %0d want 199", d);
        end
        rtc_pulse(1);
        checks++;
        if (mtip !== 1'b1) begin
            fails++;
            $display("FAIL mtip_fire: mtip=%b want 1", mtip);
        end
        rtc_pulse(3);
        checks++;
        if (mtip !== 1'b1) begin
            fails++;
            $display("FAIL mtip_level: mtip=%b want 1", mtip);
        end
        bus_read(16'hBFF8, d, r);
        checks++;
        if (d !== 32'd203) begin
            fails++;
            $display("FAIL mtime_203: got %0d want 203", d);
        end
    endtask

    task automatic test_mtime_write;
        logic [31:0] d;
        logic        r;
        bus_write(16'hBFF8, 32'd0, 4'hF);
        bus_write(16'hBFFC, 32'd0, 4'hF);
        checks++;
        if (mtip !== 1'b0) begin
            fails++;
            $display("FAIL mtip_drop: mtip=%b want 0", mtip);
        end
        rtc_pulse(3);
        bus_read(16'hBFF8, d, r);
        checks++;
        if (d !== 32'd3) begin
            fails++;
            $display("FAIL restart_3: got %0d want 3", d);
        end
        rtc_pulse(1);
        bus_read(16'hBFF8, d, r);
        checks++;
        if (d !== 32'd4) begin
            fails++;
            $display("FAIL restart_4: got %0d want 4", d);
        end
        bus_read(16'hBFFC, d, r);
        checks++;
        if (d !== 32'd0) begin
            fails++;
            $display("FAIL restart_hi: got %0d want 0", d);
        end
    endtask

    task automatic test_collision;
        logic [31:0] d;
        logic        r;
        @(negedge clk);
        rtc = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        valid = 1'b1; address = 16'hBFF8; wdata = 32'd50; wstrb = 4'hF;
        @(negedge clk);
        valid = 1'b0; wstrb = '0;
        repeat (3) @(negedge clk);
        rtc = 1'b0;
        repeat (4) @(negedge clk);
        bus_read(16'hBFF8, d, r);
        checks++;
        if (d !== 32'd50) begin
            fails++;
            $display("FAIL write_priority: got %0d want 50", d);
        end
    endtask

    task automatic test_wrap;
        logic [31:0] d;
        logic        r;
        bus_write(16'hBFFC, 32'h0, 4'hF);
        bus_write(16'hBFF8, 32'hFFFF_FFFF, 4'hF);
        rtc_pulse(1);
        bus_read(16'hBFF8, d, r);
        checks++;
        if (d !== 32'h0) begin
            fails++;
            $display("FAIL wrap_lo: got %h want 0", d);
        end
        bus_read(16'hBFFC, d, r);
        checks++;
        if (d !== 32'h1) begin
            fails++;
            $display("FAIL wrap_hi: got %h want 1", d);
        end
        checks++;
        if (mtip !== 1'b1) begin
            fails++;
            $display("FAIL mtip_64bit: mtip=%b want 1", mtip);
        end
    endtask

    task automatic test_reset_abort;
        logic [31:0] d;
        logic        r;
        @(negedge clk);
        valid = 1'b1; address = 16'hBFFC; wstrb = '0;
        #2 rst = 1'b0;
        @(negedge clk);
        valid = 1'b0;
        checks++;
        if (ready !== 1'b0 || mtip !== 1'b0) begin
            fails++;
            $display("FAIL abort: ready=%b mtip=%b want 0/0", ready, mtip);
        end
        rst = 1'b1;
        bus_read(16'hBFFC, d, r);
        checks++;
        if (d !== 32'h0 || r !== 1'b1) begin
            fails++;
            $display("FAIL post_abort_hi: rdata=%h ready=%b want 0/1", d, r);
        end
        bus_read(16'h4000, d, r);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin
            fails++;
            $display("FAIL post_abort_cmp: got %h want ffffffff", d);
        end
    endtask

    initial begin
        test_reset;
        test_strobe;
        test_msip;
        test_unmapped;
        test_timer;
        test_mtime_write;
        test_collision;
        test_wrap;
        test_reset_abort;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/iob_clint_top.md
IOB_CLINT_TOP -- requirements
Module: iob_clint_top

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, native-bus byte-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, bus data width (only 32 supported).
REQ-003 The block SHALL have parameter N_CORES, default 1, number of harts (1..8).
REQ-004 The block SHALL have port clk, input, 1, the single system clock.
REQ-005 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port rtc, input, 1, real-time clock, asynchronous to clk, slower than clk/4.
REQ-007 The block SHALL have port valid, input, 1, request strobe.
REQ-008 The block SHALL have port address, input, ADDR_W, byte address.
REQ-009 The block SHALL have port wdata, input, DATA_W, write data.
REQ-010 The block SHALL have port wstrb, input, DATA_W/8, byte write enables; all-zero means read.
REQ-011 The block SHALL have port rdata, output, DATA_W, registered read data.
REQ-012 The block SHALL have port ready, output, 1, response strobe.
REQ-013 The block SHALL have port mtip, output, N_CORES, machine timer interrupt per hart.
REQ-014 The block SHALL have port msip, output, N_CORES, machine software interrupt per hart.

Function
REQ-015 The memory map SHALL be: msip[h] at 0x0000+4h; mtimecmp[h] low word at 0x4000+8h, high word at +4; mtime low word at 0xBFF8, high word at 0xBFFC.
REQ-016 The bus SHALL answer every valid with ready=1 exactly one clk cycle later, for one cycle; ready SHALL be 0 otherwise.
REQ-017 A write SHALL update only the bytes whose wstrb bit is set; the register value SHALL change at the clk edge that samples valid.
REQ-018 A read SHALL return the addressed 32-bit word on rdata in the cycle ready is high.
REQ-019 msip[h] SHALL be one bit, stored in bit 0 of its word; bits 31:1 SHALL read as 0 and ignore writes.
REQ-020 Unmapped addresses, including hart indices >= N_CORES, SHALL read 0, ignore writes, and still return ready.
REQ-021 rtc SHALL pass through a 2-flop synchronizer in the clk domain, followed by rising-edge detection.
REQ-022 mtime SHALL be a 64-bit counter that increments by 1 once per detected rtc rising edge and wraps from 2^64-1 to 0.
REQ-023 A bus write to mtime in the same cycle as an increment SHALL take priority; the increment in that cycle SHALL be lost.
REQ-024 mtip[h] SHALL equal (mtime >= mtimecmp[h]) as an unsigned 64-bit comparison, registered, so it lags mtime by one clk cycle.
REQ-025 mtip SHALL be level-sensitive; it SHALL clear only when software raises mtimecmp[h] or lowers mtime.
REQ-026 The msip output SHALL drive the msip register bits directly.
REQ-027 A 64-bit register SHALL be updated only by two 32-bit word writes; no atomicity across the two words SHALL be provided.

Reset
REQ-028 While rst=0, the block SHALL asynchronously force: mtime=0; mtimecmp[h]=all ones; msip=0; mtip=0; ready=0; rdata=0; synchronizer and edge-detect flops=0.
REQ-029 Reset in the middle of a transaction SHALL abort it with no ready pulse.
REQ-030 After rst rises, the block SHALL start operating on the next clk edge.

Verification
REQ-031 Reset -> mtip=0, msip=0, a read of 0xBFF8 returns 0 one cycle later with ready=1.
REQ-032 Write 200 to 0x4000 and 0 to 0x4004 (wstrb=0xF) -> mtip[0] stays 0 until mtime reaches 200 rtc edges, then goes 1 and stays 1.
REQ-033 Write 1 to 0x0000 -> msip[0]=1 the next cycle; then write 0 -> msip[0]=0 the next cycle.
REQ-034 With mtip[0]=1, write 0 to 0xBFF8 and 0xBFFC -> mtip[0] drops within 2 cycles; mtime restarts from 0; reads of 0xBFF8/0xBFFC show a monotonically rising count.
REQ-035 Write 0xAB to 0x4000 with wstrb=0x1 after reset -> reading 0x4000 returns 0xFFFFFFAB.
REQ-036 Set mtime low word to 0xFFFFFFFF (high=0) and wait one rtc edge -> reads return low=0, high=1.
